// File: rtl/p2tdm.sv
// p2tdm: 256-bit parallel frame to TDM serializer; optional underrunCnt output with P2TDM_UNDERRUN_CNT_EN
module p2tdm (
    input  logic         clk,
    input  logic         rst,
    input  logic         enable,
    input  logic [7:0]   clkDiv,
    input  logic         pvalid,
    output logic         pready,
    input  logic [255:0] pdata,
    output logic         sclk,
    output logic         fs,
    output logic         tdmout,
    output logic         frameStart,
    output logic         underrun
`ifdef P2TDM_UNDERRUN_CNT_EN
    ,
    output logic [15:0]  underrunCnt
`endif
);
    typedef enum logic [1:0] {IDLE, WAIT, LEAD, SHIFT} state_t;
    state_t state, state_n;
    logic [7:0] div, cnt, idx;
    logic [255:0] hold, shreg;
    logic hold_full, hold_next, fall, xfer, last, load, ur;
    // next state and per-cycle control; fs during bit 0 marks a chained frame
    always_comb begin
        fall = (state != IDLE) && sclk && (cnt == div);
        xfer = pvalid && pready;
        last = (state == SHIFT) && (idx == 8'd0);
        load = fall && ((state == LEAD) || (last && fs));
        ur = fall && last && !fs;
        hold_next = load ? 1'b0 : (hold_full || xfer);
        state_n = state;
        case (state)
            IDLE:    state_n = WAIT;
            WAIT:    state_n = (fall && hold_full) ? LEAD : WAIT;
            LEAD:    state_n = fall ? SHIFT : LEAD;
            default: state_n = ur ? WAIT : SHIFT;
        endcase
    end
    // bit clock divider captured when leaving IDLE, ignored afterwards
    always_ff @(posedge clk) begin
        if (rst)
            div <= 8'd0;
        else if (enable && state == IDLE)
            div <= clkDiv;
    end
    // state, sclk generation, holding buffer and shift register; fs/tdmout move only on sclk fall
    always_ff @(posedge clk) begin
        if (rst || !enable) begin
            state <= IDLE;
            sclk <= 1'b0;
            fs <= 1'b0;
            tdmout <= 1'b0;
            pready <= 1'b0;
            frameStart <= 1'b0;
            underrun <= 1'b0;
            hold_full <= 1'b0;
            hold <= '0;
            shreg <= '0;
            idx <= 8'd255;
            cnt <= 8'd0;
        end else begin
            state <= state_n;
            pready <= !hold_next;
            hold_full <= hold_next;
            if (xfer)
                hold <= pdata;
            frameStart <= load;
            underrun <= ur;
            cnt <= (state == IDLE || cnt == div) ? 8'd0 : cnt + 8'd1;
            sclk <= (state != IDLE) && (sclk ^ (cnt == div));
            if (fall) begin
                if (load) begin
                    shreg <= hold;
                    tdmout <= hold[255];
                    idx <= 8'd255;
                    fs <= 1'b0;
                end else if (state == SHIFT && !last) begin
                    shreg <= {shreg[254:0], 1'b0};
                    tdmout <= shreg[254];
                    idx <= idx - 8'd1;
                    fs <= (idx == 8'd1) && hold_full;
                end else begin
                    shreg <= '0;
                    tdmout <= 1'b0;
                    idx <= 8'd255;
                    fs <= (state == WAIT) && hold_full;
                end
            end
        end
    end
`ifdef P2TDM_UNDERRUN_CNT_EN
    // saturating underrun event counter, survives enable toggling
    always_ff @(posedge clk) begin
        if (rst)
            underrunCnt <= 16'd0;
        else if (underrun && underrunCnt != 16'hFFFF)
            underrunCnt <= underrunCnt + 16'd1;
    end
`endif
endmodule
